// File: rtl/buckeye_shift_ctrl.sv
// Buckeye preamp/shaper serial configuration master: shifts NCHIP lanes of NBITS each
// through AMPIN/AMPCLK while capturing the chips' previous contents from AMPOUT.
// Optional write-verify shadow is enabled by defining BKY_VERIFY_EN.
module buckeye_shift_ctrl #(
    parameter int NCHIP   = 6,
    parameter int NBITS   = 48,
    parameter int CLK_DIV = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [NCHIP-1:0]       MASK,
    input  logic [NCHIP*NBITS-1:0] DIN,
    output logic [NCHIP*NBITS-1:0] DOUT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [NCHIP-1:0]       AMPIN,
    output logic [NCHIP-1:0]       AMPCLK,
    input  logic [NCHIP-1:0]       AMPOUT
`ifdef BKY_VERIFY_EN
    ,
    output logic [NCHIP-1:0]       VERIFY_ERR
`endif
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                      state_r;
    state_t                      state_s;
    logic [DW-1:0]               div_cnt_r;
    logic [BW-1:0]               bit_cnt_r;
    logic [NCHIP-1:0]            mask_lat_r;
    logic [NCHIP-1:0][NBITS-1:0] din_sh_r;
    logic [NCHIP-1:0][NBITS-1:0] dout_r;
    logic [NCHIP-1:0][NBITS-1:0] din_shift_s;
    logic [NCHIP-1:0][NBITS-1:0] dout_shift_s;
    logic [NCHIP-1:0]            lane_bit_s;
    logic                        busy_r;
    logic                        done_r;
    logic [NCHIP-1:0]            ampin_r;
    logic [NCHIP-1:0]            ampclk_r;
    logic                        run_s;
    logic                        div_last_s;
    logic                        bit_last_s;
    logic                        accept_s;
    logic                        sample_s;
    logic                        advance_s;

    assign run_s      = (state_r == LOW) || (state_r == HIGH);
    assign div_last_s = (div_cnt_r == DW'(CLK_DIV - 1));
    assign bit_last_s = (bit_cnt_r == BW'(NBITS - 1));

    // Write data leaves LSB first; readback enters at the MSB so bit 0 ends up holding the first sample.
    for (genvar g = 0; g < NCHIP; g++) begin : g_lane
        assign din_shift_s[g]  = {1'b0, din_sh_r[g][NBITS-1:1]};
        assign dout_shift_s[g] = {AMPOUT[g] & mask_lat_r[g], dout_r[g][NBITS-1:1]};
        assign lane_bit_s[g]   = din_sh_r[g][0] & mask_lat_r[g];
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        sample_s  = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (START) begin
                    accept_s = 1'b1;
                    state_s  = (MASK == {NCHIP{1'b0}}) ? FIN : LOW;
                end else begin
                    state_s = IDLE;
                end
            end
            LOW: begin
                if (div_last_s) begin
                    sample_s = 1'b1;
                    state_s  = HIGH;
                end else begin
                    state_s = LOW;
                end
            end
            HIGH: begin
                if (div_last_s) begin
                    if (bit_last_s) begin
                        state_s = FIN;
                    end else begin
                        advance_s = 1'b1;
                        state_s   = LOW;
                    end
                end else begin
                    state_s = HIGH;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, divider/bit counters and the data shifters
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            div_cnt_r  <= {DW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            mask_lat_r <= {NCHIP{1'b0}};
            din_sh_r   <= {(NCHIP*NBITS){1'b0}};
            dout_r     <= {(NCHIP*NBITS){1'b0}};
        end else begin
            state_r <= state_s;
            if (run_s && !div_last_s) begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end else begin
                div_cnt_r <= {DW{1'b0}};
            end
            if (accept_s) begin
                mask_lat_r <= MASK;
                din_sh_r   <= DIN;
                dout_r     <= {(NCHIP*NBITS){1'b0}};
                bit_cnt_r  <= {BW{1'b0}};
            end else begin
                if (advance_s) begin
                    din_sh_r  <= din_shift_s;
                    bit_cnt_r <= bit_cnt_r + BW'(1);
                end
                if (sample_s) begin
                    dout_r <= dout_shift_s;
                end
            end
        end
    end

    // Pin and status registers follow the state one cycle later, so AMPOUT is
    // sampled on the LOW->HIGH state change before AMPCLK actually rises.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ampin_r  <= {NCHIP{1'b0}};
            ampclk_r <= {NCHIP{1'b0}};
        end else begin
            busy_r   <= run_s;
            done_r   <= (state_r == FIN);
            ampin_r  <= run_s ? lane_bit_s : {NCHIP{1'b0}};
            ampclk_r <= (state_r == HIGH) ? mask_lat_r : {NCHIP{1'b0}};
        end
    end

    assign DOUT   = dout_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign AMPIN  = ampin_r;
    assign AMPCLK = ampclk_r;

`ifdef BKY_VERIFY_EN
    logic [NCHIP-1:0][NBITS-1:0] din_lat_r;
    logic [NCHIP-1:0][NBITS-1:0] shadow_r;
    logic [NCHIP-1:0][NBITS-1:0] shadow_nx_s;
    logic [NCHIP-1:0]            shadow_vld_r;
    logic [NCHIP-1:0]            err_s;
    logic [NCHIP-1:0]            verify_err_r;

    for (genvar g = 0; g < NCHIP; g++) begin : g_verify
        assign err_s[g]       = mask_lat_r[g] & shadow_vld_r[g] & (dout_r[g] != shadow_r[g]);
        assign shadow_nx_s[g] = mask_lat_r[g] ? din_lat_r[g] : shadow_r[g];
    end

    // Readback compare against the previously written data, then shadow refresh
    always_ff @(posedge CLK) begin
        if (RST) begin
            din_lat_r    <= {(NCHIP*NBITS){1'b0}};
            shadow_r     <= {(NCHIP*NBITS){1'b0}};
            shadow_vld_r <= {NCHIP{1'b0}};
            verify_err_r <= {NCHIP{1'b0}};
        end else begin
            if (accept_s) begin
                din_lat_r <= DIN;
            end
            if (state_r == FIN) begin
                verify_err_r <= err_s;
                shadow_r     <= shadow_nx_s;
                shadow_vld_r <= shadow_vld_r | mask_lat_r;
            end
        end
    end

    assign VERIFY_ERR = verify_err_r;
`endif

endmodule
